// File: rtl/adder_pkg.sv
// Shared constants and types for the two-requester adder arbiter.
package adder_pkg;

    localparam int WIDTH = 16;
    localparam int LAT   = 4;

    // Requester identity carried alongside each operation.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    // One slot of the tag pipeline that shadows the datapath.
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } tag_t;

    // The requester that is not 'id'.
    function automatic req_id_t other(input req_id_t id);
        return (id == REQ0) ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Request/result bundle between two requesters and the shared adder arbiter.
interface adder_arbiter_if #(
    parameter int WIDTH = adder_pkg::WIDTH
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             res0_valid;
    logic [WIDTH-1:0] res0_sum;
    logic             res0_cout;

    logic             res1_valid;
    logic [WIDTH-1:0] res1_sum;
    logic             res1_cout;

    logic             busy;

    // Requester side: drives operations, receives grants and results.
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req0_ready, req1_ready,
        input  res0_valid, res0_sum, res0_cout,
        input  res1_valid, res1_sum, res1_cout,
        input  busy
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req0_ready, req1_ready,
        output res0_valid, res0_sum, res0_cout,
        output res1_valid, res1_sum, res1_cout,
        output busy
    );

endinterface

// File: rtl/adder_16bit.sv
// Pipelined adder: sum and carry-out appear LAT cycles after the operands.
module adder_16bit #(
    parameter int WIDTH = adder_pkg::WIDTH,
    parameter int LAT   = adder_pkg::LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] total;
    logic [WIDTH:0] stage_q [LAT];

    // Full-width add with carry, computed at the pipeline input.
    always_comb total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

    // First stage captures the sum; later stages only delay it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the stage array is reset explicitly so no stale sum can surface
            // after a reset; non-blocking assignments make the shift order-independent.
            for (int i = 0; i < LAT; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= total;
            for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign {cout, sum} = stage_q[LAT-1];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one pipelined adder between two requesters.
module adder_arbiter #(
    parameter int WIDTH = adder_pkg::WIDTH,
    parameter int LAT   = adder_pkg::LAT
) (
    input  logic           clk,
    input  logic           reset,
    adder_arbiter_if.slave bus
);
    import adder_pkg::req_id_t;
    import adder_pkg::tag_t;
    import adder_pkg::REQ0;
    import adder_pkg::REQ1;
    import adder_pkg::other;

    req_id_t          ptr_q, ptr_d;
    logic             grant0, grant1;

    tag_t             iss_tag;
    logic [WIDTH-1:0] iss_a, iss_b;
    logic             iss_cin;

    tag_t             tag_q [LAT];
    tag_t             out_tag;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic [WIDTH-1:0] sum0_q, sum1_q;
    logic             cout0_q, cout1_q;
    logic             hit0, hit1;

    // Grant: a lone valid wins outright; a tie goes to the pointer.
    always_comb begin
        // NOTE: defaults first so every path assigns both grants and no latch appears.
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (reset) begin
            if (bus.req0_valid && (!bus.req1_valid || ptr_q == REQ0)) grant0 = 1'b1;
            else if (bus.req1_valid)                                  grant1 = 1'b1;
        end
    end

    // Pointer advances past the winner only when both requesters competed.
    always_comb begin
        ptr_d = ptr_q;
        if (bus.req0_valid && bus.req1_valid) ptr_d = other(ptr_q);
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr_q <= REQ0;
        else        ptr_q <= ptr_d;
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // Issue stage: register the accepted operation and its tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_tag <= '0;
            iss_a   <= '0;
            iss_b   <= '0;
            iss_cin <= 1'b0;
        end else begin
            iss_tag.valid <= grant0 | grant1;
            iss_tag.id    <= grant1 ? REQ1 : REQ0;
            if (grant1) begin
                iss_a   <= bus.req1_a;
                iss_b   <= bus.req1_b;
                iss_cin <= bus.req1_cin;
            end else if (grant0) begin
                iss_a   <= bus.req0_a;
                iss_b   <= bus.req0_b;
                iss_cin <= bus.req0_cin;
            end
        end
    end

    adder_16bit #(
        .WIDTH (WIDTH),
        .LAT   (LAT)
    ) u_adder (
        .clk   (clk),
        .rst_n (reset),
        .a     (iss_a),
        .b     (iss_b),
        .cin   (iss_cin),
        .sum   (add_sum),
        .cout  (add_cout)
    );

    // Tag pipeline: moves in lockstep with the adder stages.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= iss_tag;
            for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign out_tag = tag_q[LAT-1];
    assign hit0    = out_tag.valid && (out_tag.id == REQ0);
    assign hit1    = out_tag.valid && (out_tag.id == REQ1);

    // Per-requester copies of the last delivered result, shown between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum0_q  <= '0;
            cout0_q <= 1'b0;
            sum1_q  <= '0;
            cout1_q <= 1'b0;
        end else begin
            if (hit0) begin
                sum0_q  <= add_sum;
                cout0_q <= add_cout;
            end
            if (hit1) begin
                sum1_q  <= add_sum;
                cout1_q <= add_cout;
            end
        end
    end

    // Result steering and in-flight indication.
    always_comb begin
        bus.res0_valid = hit0;
        bus.res0_sum   = hit0 ? add_sum  : sum0_q;
        bus.res0_cout  = hit0 ? add_cout : cout0_q;
        bus.res1_valid = hit1;
        bus.res1_sum   = hit1 ? add_sum  : sum1_q;
        bus.res1_cout  = hit1 ? add_cout : cout1_q;
        bus.busy       = iss_tag.valid;
        for (int i = 0; i < LAT; i++) bus.busy = bus.busy | tag_q[i].valid;
    end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: reference model of the grant logic plus a result scoreboard.
module tb_adder_arbiter;
    import adder_pkg::*;

    typedef struct {
        req_id_t          id;
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               due;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t             sb [$];
    req_id_t          ptr_m = REQ0;
    logic [WIDTH-1:0] last_sum0 = '0, last_sum1 = '0;
    logic             last_cout0 = 1'b0, last_cout1 = 1'b0;

    exp_t             me;
    req_id_t          got_id;
    logic [WIDTH-1:0] got_sum;
    logic             got_cout;

    adder_arbiter_if #(.WIDTH(WIDTH)) bus ();

    adder_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Result monitor: every pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.res0_valid && bus.res1_valid) begin
                n_cmp++; n_bad++;
                $display("FAIL res_both: res0_valid=1 res1_valid=1, required at most one");
            end
            if (bus.res0_valid || bus.res1_valid) begin
                got_id   = bus.res1_valid ? REQ1 : REQ0;
                got_sum  = bus.res1_valid ? bus.res1_sum  : bus.res0_sum;
                got_cout = bus.res1_valid ? bus.res1_cout : bus.res0_cout;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL res_unexpected: pulse for req%0d sum=%0h at cycle %0d, required none",
                             got_id, got_sum, cyc);
                end else begin
                    me = sb.pop_front();
                    if (got_id !== me.id) begin
                        n_bad++;
                        $display("FAIL res_id: got req%0d required req%0d", got_id, me.id);
                    end
                    n_cmp++;
                    if (got_sum !== me.sum) begin
                        n_bad++;
                        $display("FAIL res_sum: got %0h required %0h", got_sum, me.sum);
                    end
                    n_cmp++;
                    if (got_cout !== me.cout) begin
                        n_bad++;
                        $display("FAIL res_cout: got %0b required %0b", got_cout, me.cout);
                    end
                    n_cmp++;
                    if (cyc !== me.due) begin
                        n_bad++;
                        $display("FAIL res_latency: pulse at cycle %0d required %0d", cyc, me.due);
                    end
                    n_cmp++;
                    if (got_id == REQ0) begin
                        if (bus.res1_sum !== last_sum1 || bus.res1_cout !== last_cout1) begin
                            n_bad++;
                            $display("FAIL res1_hold: got %0h/%0b required %0h/%0b",
                                     bus.res1_sum, bus.res1_cout, last_sum1, last_cout1);
                        end
                        last_sum0  = me.sum;
                        last_cout0 = me.cout;
                    end else begin
                        if (bus.res0_sum !== last_sum0 || bus.res0_cout !== last_cout0) begin
                            n_bad++;
                            $display("FAIL res0_hold: got %0h/%0b required %0h/%0b",
                                     bus.res0_sum, bus.res0_cout, last_sum0, last_cout0);
                        end
                        last_sum1  = me.sum;
                        last_cout1 = me.cout;
                    end
                end
            end
        end
    end

    // One cycle of stimulus: check grants against the model, log accepted ops.
    task automatic drive(input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                         input logic c0, input logic v1, input logic [WIDTH-1:0] a1,
                         input logic [WIDTH-1:0] b1, input logic c1);
        logic           g0, g1;
        logic [WIDTH:0] t;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_cin = c0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_cin = c1;
        #1;
        g0 = v0 && (!v1 || ptr_m == REQ0);
        g1 = v1 && !g0;
        n_cmp++;
        if (bus.req0_ready !== g0) begin
            n_bad++;
            $display("FAIL req0_ready: got %0b required %0b at cycle %0d", bus.req0_ready, g0, cyc);
        end
        n_cmp++;
        if (bus.req1_ready !== g1) begin
            n_bad++;
            $display("FAIL req1_ready: got %0b required %0b at cycle %0d", bus.req1_ready, g1, cyc);
        end
        if (g0) begin
            t = {1'b0, a0} + {1'b0, b0} + {{WIDTH{1'b0}}, c0};
            sb.push_back('{REQ0, t[WIDTH-1:0], t[WIDTH], cyc + 1 + LAT});
        end
        if (g1) begin
            t = {1'b0, a1} + {1'b0, b1} + {{WIDTH{1'b0}}, c1};
            sb.push_back('{REQ1, t[WIDTH-1:0], t[WIDTH], cyc + 1 + LAT});
        end
        if (v0 && v1) ptr_m = (ptr_m == REQ0) ? REQ1 : REQ0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && sb.size() != 0; i++) idle(1);
        #1;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_%s: %0d results still outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic enter_reset();
        reset = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        sb.delete();
        ptr_m      = REQ0;
        last_sum0  = '0; last_cout0 = 1'b0;
        last_sum1  = '0; last_cout1 = 1'b0;
    endtask

    task automatic test_reset();
        enter_reset();
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        n_cmp++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_ready: got %b required 00", {bus.req0_ready, bus.req1_ready});
        end
        n_cmp++;
        if ({bus.res0_valid, bus.res1_valid, bus.busy} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_valid_busy: got %b required 000", {bus.res0_valid, bus.res1_valid, bus.busy});
        end
        n_cmp++;
        if ({bus.res0_sum, bus.res0_cout, bus.res1_sum, bus.res1_cout} !== '0) begin
            n_bad++;
            $display("FAIL reset_sums: got %0h/%0b %0h/%0b required zeros",
                     bus.res0_sum, bus.res0_cout, bus.res1_sum, bus.res1_cout);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Single request right after reset release, then measure the busy window.
    task automatic test_single_busy();
        int cnt;
        drive(1'b1, 16'd3, 16'd8, 1'b0, 1'b0, '0, '0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy === 1'b1) cnt++;
            else break;
            idle(1);
        end
        n_cmp++;
        if (cnt !== LAT + 1) begin
            n_bad++;
            $display("FAIL busy_window: high for %0d cycles required %0d", cnt, LAT + 1);
        end
        wait_drain("single");
    endtask

    task automatic test_both_first();
        enter_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 16'd3, 16'd3, 1'b0, 1'b1, 16'd7, 16'd1, 1'b0);
        drive(1'b1, 16'd3, 16'd3, 1'b0, 1'b1, 16'd7, 16'd1, 1'b0);
        idle(1);
        wait_drain("both");
    endtask

    task automatic test_alternate();
        for (int i = 0; i < 6; i++)
            drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                  1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        idle(1);
        wait_drain("alternate");
    endtask

    task automatic test_carry();
        drive(1'b0, '0, '0, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
        drive(1'b1, 16'd13, 16'd93, 1'b0, 1'b0, '0, '0, 1'b0);
        idle(1);
        wait_drain("carry");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 30; i++)
            drive(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                  1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        idle(1);
        wait_drain("b2b");
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 16'd13, 16'd29, 1'b0, 1'b0, '0, '0, 1'b0);
        // Leave the pointer at requester 1 so its reset value is observable.
        if (ptr_m == REQ0) drive(1'b1, 16'd1, 16'd2, 1'b0, 1'b1, 16'd4, 16'd5, 1'b0);
        else               idle(1);
        enter_reset();
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if ({bus.busy, bus.res0_valid, bus.res1_valid} !== 3'b000) begin
                n_bad++;
                $display("FAIL midreset_busy: got %b required 000", {bus.busy, bus.res0_valid, bus.res1_valid});
            end
            @(negedge clk);
        end
        reset = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            n_cmp++;
            if (bus.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL postreset_busy: got %b required 0", bus.busy);
            end
            idle(1);
        end
        drive(1'b1, 16'd100, 16'd200, 1'b0, 1'b1, 16'd5, 16'd6, 1'b1);
        idle(1);
        wait_drain("reset_mid");
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;
        test_reset();
        test_single_busy();
        test_both_first();
        test_alternate();
        test_carry();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
